trace_capture_unit: RTL and testbench

TRACE_CAPTURE_UNIT -- requirements
Module: trace_capture_unit

---
 rtl/trace_pkg.sv | 39 +++
 rtl/trace_ram.sv | 32 +++
 rtl/trace_capture_unit.sv | 179 +++++++++++++++++
 tb/tb_trace_capture_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// ============================================================================
// trace_pkg: shared types and constants for the trace capture unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package trace_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_POST  = 3'd2,
      ST_DONE  = 3'd3,
      ST_DRAIN = 3'd4
   } trace_state_e;

   localparam logic TRIG_MODE_PC = 1'b0;
   localparam logic TRIG_MODE_RD = 1'b1;

   localparam int RD_W    = 5;
   localparam int STALL_W = 8;
   localparam int META_W  = STALL_W + 2 + 2 + 1;

   // Low-order tail of every entry; pc, rd and data sit above it.
   typedef struct packed {
      logic [STALL_W-1:0] stall_cnt;
      logic [1:0]         fwd_a;
      logic [1:0]         fwd_b;
      logic               cache_hit;
   } trace_meta_t;

   function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v,
                                                  input logic               inc);
      return (inc && (v != '1)) ? v + 1'b1 : v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/trace_ram.sv
// ============================================================================
// trace_ram: DEPTH x WIDTH register array, one write port, async read port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module trace_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 82,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/trace_capture_unit.sv
// ============================================================================
// trace_capture_unit: circular pre/post-trigger commit trace with drain port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module trace_capture_unit
   import trace_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int XLEN      = 32,
   parameter int POST_TRIG = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 commit_valid_i,
   input  logic [XLEN-1:0]      commit_pc_i,
   input  logic [4:0]           commit_rd_i,
   input  logic [XLEN-1:0]      commit_data_i,
   input  logic                 stall_i,
   input  logic [1:0]           fwd_a_i,
   input  logic [1:0]           fwd_b_i,
   input  logic                 cache_hit_i,
   input  logic                 arm_i,
   input  logic                 trig_mode_i,
   input  logic [XLEN-1:0]      trig_pc_i,
   input  logic [4:0]           trig_rd_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [2*XLEN+17:0]   out_entry_o,
   output logic [2:0]           state_o,
   output logic                 overflow_o
);

   localparam int ENTRY_W = 2*XLEN + RD_W + META_W;
   localparam int AW      = $clog2(DEPTH);
   localparam int CNT_W   = AW + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   trace_state_e       state_q, state_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   post_q, post_d;
   logic [STALL_W-1:0] stall_q, stall_d;
   logic               overflow_q, overflow_d;

   logic               capturing;
   logic               restart;
   logic               trig_hit;
   logic               ram_we;
   logic [STALL_W-1:0] stall_sum;
   trace_meta_t        meta;
   logic [ENTRY_W-1:0] ram_wdata;
   logic [ENTRY_W-1:0] ram_rdata;
   logic [AW-1:0]      rd_addr;

   assign capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
   assign restart   = arm_i && (state_q != ST_DRAIN);
   assign trig_hit  = commit_valid_i &&
                      ((trig_mode_i == TRIG_MODE_PC) ? (commit_pc_i == trig_pc_i)
                                                     : ((commit_rd_i == trig_rd_i) &&
                                                        (commit_rd_i != 5'd0)));
   assign ram_we    = capturing && commit_valid_i && !arm_i;

   // A stall coinciding with a commit is charged to that commit's entry.
   assign stall_sum = sat_inc(stall_q, stall_i);

   assign meta.stall_cnt = stall_sum;
   assign meta.fwd_a     = fwd_a_i;
   assign meta.fwd_b     = fwd_b_i;
   assign meta.cache_hit = cache_hit_i;
   assign ram_wdata      = {commit_pc_i, commit_rd_i, commit_data_i, meta};

   // During drain count_q is the number still to emit, so the oldest
   // unread entry is always wr_ptr - count (a full buffer reads from wr_ptr).
   assign rd_addr = wr_ptr_q - count_q[AW-1:0];

   trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W),
      .AW    (AW)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (ram_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (ram_wdata),
      .raddr_i (rd_addr),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      post_d     = post_q;
      stall_d    = stall_q;
      overflow_d = overflow_q;
      if (restart) begin
         state_d    = ST_ARMED;
         wr_ptr_d   = '0;
         count_d    = '0;
         post_d     = '0;
         stall_d    = '0;
         overflow_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_ARMED, ST_POST: begin
               stall_d = stall_sum;
               if (commit_valid_i) begin
                  stall_d  = '0;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  if (count_q == FULL_CNT) begin
                     overflow_d = 1'b1;
                  end else begin
                     count_d = count_q + 1'b1;
                  end
                  if (state_q == ST_ARMED) begin
                     if (trig_hit) begin
                        if (POST_TRIG == 0) begin
                           state_d = ST_DONE;
                        end else begin
                           state_d = ST_POST;
                           post_d  = CNT_W'(POST_TRIG);
                        end
                     end
                  end else begin
                     post_d = post_q - 1'b1;
                     if (post_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                     end
                  end
               end
            end
            ST_DONE: begin
               if (out_ready_i) begin
                  state_d = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (count_q == '0) begin
                  state_d = ST_IDLE;
               end else if (out_ready_i) begin
                  count_d = count_q - 1'b1;
                  if (count_q == CNT_W'(1)) begin
                     state_d = ST_IDLE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         post_q     <= '0;
         stall_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         post_q     <= post_d;
         stall_q    <= stall_d;
         overflow_q <= overflow_d;
      end
   end

   assign out_valid_o = (state_q == ST_DRAIN) && (count_q != '0);
   assign out_entry_o = out_valid_o ? ram_rdata : '0;
   assign state_o     = state_q;
   assign overflow_o  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_trace_capture_unit.sv
// ============================================================================
// tb_trace_capture_unit: randomized scoreboard bench for trace_capture_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_trace_capture_unit;
   import trace_pkg::*;

   localparam int DEPTH     = 16;
   localparam int XLEN      = 32;
   localparam int POST_TRIG = 4;
   localparam int ENTRY_W   = 2*XLEN + 18;

   localparam int P_IDLE = 0, P_CAPT = 1, P_POST = 2, P_DONE = 3, P_DRAIN = 4;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               commit_valid;
   logic [XLEN-1:0]    commit_pc, commit_data, trig_pc;
   logic [4:0]         commit_rd, trig_rd;
   logic               stall, cache_hit, arm, trig_mode, out_ready, out_valid, overflow;
   logic [1:0]         fwd_a, fwd_b;
   logic [ENTRY_W-1:0] out_entry;
   logic [2:0]         state;

   always #5 clk = ~clk;

   trace_capture_unit #(.DEPTH(DEPTH), .XLEN(XLEN), .POST_TRIG(POST_TRIG)) dut (
      .clk_i(clk), .rst_ni(rst_n), .commit_valid_i(commit_valid), .commit_pc_i(commit_pc),
      .commit_rd_i(commit_rd), .commit_data_i(commit_data), .stall_i(stall),
      .fwd_a_i(fwd_a), .fwd_b_i(fwd_b), .cache_hit_i(cache_hit), .arm_i(arm),
      .trig_mode_i(trig_mode), .trig_pc_i(trig_pc), .trig_rd_i(trig_rd),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_entry_o(out_entry),
      .state_o(state), .overflow_o(overflow)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: every captured commit in order; the drain is the tail.
   logic [ENTRY_W-1:0] hist [$];
   logic [ENTRY_W-1:0] sbq  [$];
   int                 phase = P_IDLE;
   int                 post_left, drain_left, stall_acc;
   logic               m_mode;
   logic [XLEN-1:0]    m_tpc;
   logic [4:0]         m_trd;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [2:0] exp_state();
      case (phase)
         P_CAPT:  return ST_ARMED;
         P_POST:  return ST_POST;
         P_DONE:  return ST_DONE;
         P_DRAIN: return ST_DRAIN;
         default: return ST_IDLE;
      endcase
   endfunction

   function automatic void model_step(input logic cv, input logic [XLEN-1:0] pc,
                                      input logic [4:0] rd, input logic [XLEN-1:0] data,
                                      input logic st, input logic a, input logic rdy,
                                      input logic [1:0] fa, input logic [1:0] fb, input logic hit);
      int  ssum, n;
      logic is_trig;
      is_trig = cv && ((m_mode == 1'b0) ? (pc == m_tpc) : ((rd == m_trd) && (rd != 0)));
      if (a && phase != P_DRAIN) begin
         hist.delete();
         stall_acc = 0;
         phase     = P_CAPT;
      end else if (phase == P_CAPT || phase == P_POST) begin
         ssum = stall_acc + int'(st);
         if (ssum > 255) ssum = 255;
         if (cv) begin
            hist.push_back({pc, rd, data, 8'(ssum), fa, fb, hit});
            stall_acc = 0;
            if (phase == P_CAPT && is_trig) begin
               if (POST_TRIG == 0) phase = P_DONE;
               else begin post_left = POST_TRIG; phase = P_POST; end
            end else if (phase == P_POST) begin
               post_left--;
               if (post_left == 0) phase = P_DONE;
            end
         end else begin
            stall_acc = ssum;
         end
      end else if (phase == P_DONE) begin
         if (rdy) begin
            phase = P_DRAIN;
            n = (hist.size() < DEPTH) ? hist.size() : DEPTH;
            for (int i = 0; i < n; i++) sbq.push_back(hist[hist.size() - n + i]);
            drain_left = n;
         end
      end else if (phase == P_DRAIN) begin
         if (rdy) begin
            drain_left--;
            if (drain_left == 0) phase = P_IDLE;
         end
      end
   endfunction

   task automatic cyc(input logic cv, input logic [XLEN-1:0] pc, input logic [4:0] rd,
                      input logic [XLEN-1:0] data, input logic st, input logic a, input logic rdy);
      logic [1:0] fa, fb;
      logic       hit;
      fa = 2'($urandom_range(0, 3));
      fb = 2'($urandom_range(0, 3));
      hit = 1'($urandom_range(0, 1));
      commit_valid = cv; commit_pc = pc; commit_rd = rd; commit_data = data;
      stall = st; arm = a; out_ready = rdy; fwd_a = fa; fwd_b = fb; cache_hit = hit;
      trig_mode = m_mode; trig_pc = m_tpc; trig_rd = m_trd;
      model_step(cv, pc, rd, data, st, a, rdy, fa, fb, hit);
      @(posedge clk);
      #1;
      check("state", 128'(state), 128'(exp_state()));
      check("out_valid", 128'(out_valid), 128'(phase == P_DRAIN));
      check("overflow", 128'(overflow), 128'(hist.size() > DEPTH));
   endtask

   task automatic commit(input logic [XLEN-1:0] pc, input logic [4:0] rd, input logic [XLEN-1:0] data);
      cyc(1'b1, pc, rd, data, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
   endtask

   task automatic do_arm();
      cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
   endtask

   // pat 0: ready always high, 1: random, 2: repeating 1,0,0,1
   task automatic drain(input int pat);
      int i = 0;
      logic rdy;
      while (phase != P_IDLE && i < 400) begin
         case (pat)
            0: rdy = 1'b1;
            1: rdy = 1'($urandom_range(0, 1));
            default: rdy = (i % 4 == 0) || (i % 4 == 3);
         endcase
         cyc(1'($urandom_range(0, 1)), $urandom, 5'($urandom), $urandom, 1'($urandom_range(0, 1)), 1'b0, rdy);
         i++;
      end
      check("drain_timeout", 128'(phase != P_IDLE), 128'(0));
      check("drain_all_seen", 128'(sbq.size()), 128'(0));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_state", 128'(state), 128'(ST_IDLE));
      check("rst_out_entry", 128'(out_entry), 128'(0));
      check("rst_overflow", 128'(overflow), 128'(0));
      hist.delete();
      sbq.delete();
      phase = P_IDLE;
      stall_acc = 0;
      drain_left = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Scoreboard monitor: pops on every accepted beat, checks holds on stalled beats.
   logic [ENTRY_W-1:0] held;
   bit                 hold = 0;
   always @(negedge clk) begin
      logic [ENTRY_W-1:0] e;
      if (!rst_n) begin
         hold = 0;
      end else begin
         if (hold) check("entry_stable", 128'({out_valid, out_entry}), 128'({1'b1, held}));
         hold = 0;
         if (out_valid) begin
            if (out_ready) begin
               if (sbq.size() == 0) begin
                  check("unexpected_entry", 128'(out_entry), 128'(0));
                  if (out_entry == '0) begin
                     errors++;
                     $display("FAIL unexpected_entry: got zero entry expected no output");
                  end
               end else begin
                  e = sbq.pop_front();
                  check("entry", 128'(out_entry), 128'(e));
               end
            end else begin
               hold = 1;
               held = out_entry;
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      commit_valid = 0; commit_pc = 0; commit_rd = 0; commit_data = 0; stall = 0;
      fwd_a = 0; fwd_b = 0; cache_hit = 0; arm = 0; trig_mode = 0; trig_pc = 0; trig_rd = 0;
      out_ready = 0;
      m_mode = 0; m_tpc = 0; m_trd = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 128'(state), 128'(ST_IDLE));
      check("reset_out_valid", 128'(out_valid), 128'(0));
      check("reset_out_entry", 128'(out_entry), 128'(0));
      check("reset_overflow", 128'(overflow), 128'(0));
      rst_n = 1'b1;

      // PC trigger at 0x20 with short history; commits after DONE are ignored.
      m_mode = TRIG_MODE_PC; m_tpc = 32'h20;
      do_arm();
      for (int p = 0; p <= 32'h40; p += 4) commit(32'(p), 5'($urandom), $urandom);
      check("pc_trig_done", 128'(state), 128'(ST_DONE));
      check("pc_trig_no_ovf", 128'(overflow), 128'(0));
      drain(0);

      // Long pre-trigger history wraps the buffer.
      m_tpc = 32'h1000;
      do_arm();
      for (int i = 0; i < 40; i++) commit(32'(i * 4), 5'($urandom), $urandom);
      commit(32'h1000, 5'd1, 32'hABCD);
      for (int i = 0; i < 4; i++) commit(32'h2000 + 32'(i * 4), 5'($urandom), $urandom);
      check("wrap_overflow", 128'(overflow), 128'(1));
      drain(1);

      // Register-match trigger: x0 never triggers, rd=5 does.
      m_mode = TRIG_MODE_RD; m_trd = 5'd0;
      do_arm();
      for (int i = 0; i < 6; i++) commit($urandom, 5'd0, $urandom);
      check("rd0_no_trigger", 128'(state), 128'(ST_ARMED));
      m_trd = 5'd5;
      do_arm();
      for (int i = 0; i < 3; i++) commit($urandom, 5'd6 + 5'(i), $urandom);
      commit(32'h444, 5'd5, 32'h7);
      check("rd5_trigger", 128'(state), 128'(ST_POST));
      for (int i = 0; i < 4; i++) commit($urandom, 5'd9, $urandom);
      drain(2);

      // Stall counting: 3 and saturated 300.
      m_mode = TRIG_MODE_PC; m_tpc = 32'hFFFF_0000;
      do_arm();
      cyc(1'b1, 32'h100, 5'd1, 32'h1, 1'b0, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 32'h104, 5'd2, 32'h2, 1'b0, 1'b0, 1'b0);
      repeat (300) cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 32'h108, 5'd3, 32'h3, 1'b0, 1'b0, 1'b0);
      commit(32'hFFFF_0000, 5'd4, 32'h4);
      for (int i = 0; i < 4; i++) commit(32'h200 + 32'(i * 4), 5'd7, $urandom);
      drain(2);

      // Reset while draining 8 entries, after 2 accepted.
      do_arm();
      for (int i = 0; i < 3; i++) commit(32'h300 + 32'(i * 4), 5'd1, $urandom);
      commit(32'hFFFF_0000, 5'd2, $urandom);
      for (int i = 0; i < 4; i++) commit(32'h400 + 32'(i * 4), 5'd3, $urandom);
      cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
      repeat (2) cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
      check("pre_reset_left", 128'(drain_left), 128'(6));
      do_reset();
      repeat (20) cyc(1'($urandom_range(0, 1)), $urandom, 5'($urandom), $urandom, 1'b0, 1'b0, 1'b1);

      // Randomized captures with occasional restarts.
      for (int it = 0; it < 6; it++) begin
         int guard = 0;
         m_mode = 1'($urandom_range(0, 1));
         m_tpc  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
         m_trd  = 5'($urandom_range(1, 31));
         do_arm();
         while (phase != P_DONE && guard < 600) begin
            cyc(1'($urandom_range(0, 1)), {24'd0, 6'($urandom_range(0, 63)), 2'b00},
                5'($urandom), $urandom, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0, 1'b0);
            guard++;
         end
         guard = 0;
         while (phase != P_DONE && guard < 20) begin
            cyc(1'b1, m_tpc, m_trd, $urandom, 1'b0, 1'b0, 1'b0);
            guard++;
         end
         drain(1);
      end

      check("final_scoreboard_empty", 128'(sbq.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
